write_once_reg_bank: RTL
========================

WRITE_ONCE_REG_BANK -- requirements
Module: write_once_reg_bank

Interface
REQ-001 SHALL have parameter DATA_W, default 16, register width in bits (>= 2).
REQ-002 SHALL have parameter ADDR_W, default 2, address width; the bank holds NUM_REGS = 2**ADDR_W registers.
REQ-003 SHALL have parameter ERR_CNT_W, default 8, width of the violation counter.
REQ-004 SHALL have port Clk  input  1  rising-edge clock.
REQ-005 SHALL have port ip_resetn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port wr_en  input  1  write strobe, one write per cycle.
REQ-007 SHALL have port wr_addr  input  ADDR_W  target register of the write.
REQ-008 SHALL have port wr_data  input  DATA_W  write payload; bit 0 is the lock request.
REQ-009 SHALL have port lock_all  input  1  one-cycle pulse that locks every register.
REQ-010 SHALL have port rd_en  input  1  read request.
REQ-011 SHALL have port rd_addr  input  ADDR_W  register to read.
REQ-012 SHALL have port err_clr  input  1  synchronous clear of err_count.
REQ-013 SHALL have port rd_data  output  DATA_W  registered read data.
REQ-014 SHALL have port rd_valid  output  1  high for one cycle when rd_data is updated.
REQ-015 SHALL have port lock_status  output  NUM_REGS  bit i is the lock state of register i.
REQ-016 SHALL have port wr_err  output  1  one-cycle pulse flagging a write to a locked register.
REQ-017 SHALL have port err_count  output  ERR_CNT_W  saturating count of rejected writes.

Function
REQ-018 Each register i SHALL store payload bits [DATA_W-1:1] plus a lock bit lock[i]; lock_status[i] = lock[i].
REQ-019 Accepted write to an unlocked register: payload <= wr_data[DATA_W-1:1] and lock[i] <= wr_data[0], both visible from the next edge.
REQ-020 A write SHALL be accepted only when wr_en=1 and lock[wr_addr]=0, sampled before the edge.
REQ-021 A write to a locked register SHALL leave the payload and lock unchanged, assert wr_err for exactly the next cycle and increment err_count by 1.
REQ-022 err_count SHALL saturate at all-ones and never wrap.
REQ-023 err_clr=1 SHALL set err_count to 0; if a rejected write occurs in the same cycle, err_count SHALL become 1.
REQ-024 lock_all=1 SHALL set every lock bit at that edge.
REQ-025 lock_all and a write to an unlocked register in the same cycle: the write SHALL commit and the register SHALL end locked.
REQ-026 Once set, a lock bit SHALL clear only on ip_resetn; no write, lock_all or err_clr clears it.
REQ-027 Read: rd_en=1 at edge N SHALL give rd_data = {payload[rd_addr], lock[rd_addr]} with rd_valid=1 after edge N (latency 1).
REQ-028 Read and write to the same address in one cycle SHALL return the pre-write value.
REQ-029 rd_en=0: rd_data SHALL hold its last value and rd_valid SHALL be 0.
REQ-030 Reads SHALL never affect lock state or err_count; reads and writes SHALL proceed concurrently without stalls.

Reset
REQ-031 ip_resetn=0 SHALL immediately force all payloads 0, all lock bits 0, rd_data 0, rd_valid 0, wr_err 0 and err_count 0, regardless of Clk.
REQ-032 Deassertion SHALL take effect at the first Clk edge with ip_resetn=1; a wr_en or rd_en asserted during reset SHALL be discarded.
REQ-033 Reset mid-operation SHALL discard any pending read result and any pending wr_err pulse.

Verification
REQ-034 Write 0x1234 to reg 1 (bit0=0), then read reg 1 -> rd_data=0x1234 one cycle later; lock_status[1]=0; second write 0xABCC to reg 1 -> read gives 0xABCC.
REQ-035 Write 0x5A5B to reg 2, then write 0xFFFF to reg 2 -> second write rejected, wr_err pulses one cycle, err_count=1, read gives 0x5A5B, lock_status[2]=1.
REQ-036 Pulse lock_all in the same cycle as a write of 0x0F00 to reg 0 -> reg 0 reads 0x0F01, lock_status=4'b1111, a later write to reg 3 sets wr_err.
REQ-037 ERR_CNT_W=2: five rejected writes -> err_count sequence 1,2,3,3,3; err_clr together with a sixth rejected write -> err_count=1.
REQ-038 Same-cycle read and write of 0x00F0 to unlocked reg 3 holding 0x0010 -> rd_data=0x0010, next read gives 0x00F0.
REQ-039 Assert ip_resetn=0 between clock edges with all registers locked -> all outputs 0 at once; after release a write of 0x0002 to reg 0 is accepted and reads back 0x0002.

Source files
------------

// File: rtl/write_once_reg_bank.sv
// Bank of write-once registers: each register commits one write, then locks
// itself (via wr_data[0] or lock_all) until reset; writes to locked registers are counted.
module write_once_reg_bank #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 2,
    parameter int ERR_CNT_W = 8
) (
    input  logic                    Clk,
    input  logic                    ip_resetn,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    lock_all,
    input  logic                    rd_en,
    input  logic [ADDR_W-1:0]       rd_addr,
    input  logic                    err_clr,
    output logic [DATA_W-1:0]       rd_data,
    output logic                    rd_valid,
    output logic [(2**ADDR_W)-1:0]  lock_status,
    output logic                    wr_err,
    output logic [ERR_CNT_W-1:0]    err_count
);

    localparam int NUM_REGS = 2**ADDR_W;

    logic [DATA_W-1:1]    payload [NUM_REGS];
    logic [NUM_REGS-1:0]  lock;
    logic [NUM_REGS-1:0]  lock_next;
    logic [ERR_CNT_W-1:0] err_next;
    logic                 wr_accept;
    logic                 wr_reject;

    assign lock_status = lock;

    // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        wr_accept = wr_en & ~lock[wr_addr];
        wr_reject = wr_en &  lock[wr_addr];

        lock_next = lock;
        if (lock_all) begin
            lock_next = '1;
        end
        // An accepted write targets an unlocked register, so OR-ing keeps a same-cycle lock_all.
        if (wr_accept) begin
            lock_next[wr_addr] = lock_next[wr_addr] | wr_data[0];
        end

        err_next = err_count;
        if (err_clr) begin
            err_next = wr_reject ? ERR_CNT_W'(1) : '0;
        end else if (wr_reject && (err_count != '1)) begin
            err_next = err_count + ERR_CNT_W'(1);
        end
    end

    // NOTE: the payload array is reset because reset must clear all stored data immediately;
    // state is updated with non-blocking assignments so all reads see pre-edge values.
    always_ff @(posedge Clk or negedge ip_resetn) begin
        if (!ip_resetn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                payload[i] <= '0;
            end
            lock      <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            wr_err    <= 1'b0;
            err_count <= '0;
        end else begin
            if (wr_accept) begin
                payload[wr_addr] <= wr_data[DATA_W-1:1];
            end
            lock      <= lock_next;
            wr_err    <= wr_reject;
            err_count <= err_next;
            rd_valid  <= rd_en;
            if (rd_en) begin
                rd_data <= {payload[rd_addr], lock[rd_addr]};
            end
        end
    end

endmodule
